// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter; the master drives commands,
// the slave (the counter) returns the count and boundary flags.
interface updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             dir;
  logic [WIDTH-1:0] out;
  logic             overflow;
  logic             underflow;
  logic             at_max;
  logic             at_zero;

  modport master (
    output clear, load, load_value, enable, dir,
    input  out, overflow, underflow, at_max, at_zero
  );

  modport slave (
    input  clear, load, load_value, enable, dir,
    output out, overflow, underflow, at_max, at_zero
  );
endinterface

// File: rtl/updown_counter.sv
// Up/down counter with programmable modulus (MAX_VALUE+1), wrap or saturate,
// clear, clamped parallel load and registered overflow/underflow pulses.
module updown_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  updown_counter_if.slave   bus
);

  logic [WIDTH-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             top;
  logic             bottom;

  assign top    = (count == MAX_VALUE);
  assign bottom = (count == '0);

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      count     <= RESET_VALUE;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.load) begin
      // Out-of-range loads clamp to the terminal count rather than wrapping.
      count     <= (bus.load_value > MAX_VALUE) ? MAX_VALUE : bus.load_value;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.enable && bus.dir) begin
      overflow  <= top;
      underflow <= 1'b0;
      if (!top)          count <= count + WIDTH'(1);
      else if (!SATURATE) count <= '0;
    end else if (bus.enable) begin
      overflow  <= 1'b0;
      underflow <= bottom;
      if (!bottom)       count <= count - WIDTH'(1);
      else if (!SATURATE) count <= MAX_VALUE;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end
  end

  assign bus.out       = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
  assign bus.at_max    = top;
  assign bus.at_zero   = bottom;

endmodule

// File: tb/tb_updown_counter.sv
// Two counters (wrap, MAX 9, reset 0 / saturate, MAX 255, reset 3) share one
// stimulus stream and are compared every cycle against an arithmetic model.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear, load, enable, dir;
  logic [7:0] load_value;

  always #5 clk = ~clk;

  updown_counter_if #(.WIDTH(8)) ia ();
  updown_counter_if #(.WIDTH(8)) ib ();

  assign ia.clear = clear; assign ia.load = load; assign ia.load_value = load_value;
  assign ia.enable = enable; assign ia.dir = dir;
  assign ib.clear = clear; assign ib.load = load; assign ib.load_value = load_value;
  assign ib.enable = enable; assign ib.dir = dir;

  updown_counter #(.WIDTH(8), .MAX_VALUE(8'd9), .SATURATE(1'b0), .RESET_VALUE(8'd0)) ua (
    .clk(clk), .reset(reset), .bus(ia)
  );
  updown_counter #(.WIDTH(8), .MAX_VALUE(8'd255), .SATURATE(1'b1), .RESET_VALUE(8'd3)) ub (
    .clk(clk), .reset(reset), .bus(ib)
  );

  int nchk = 0;
  int nfail = 0;
  bit armed = 1'b0;

  // Model state per instance
  int  ma_cnt, mb_cnt;
  bit  ma_ov, ma_un, mb_ov, mb_un;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void step(input int maxv, input bit sat, input int rv,
                               input bit rst, input bit clr, input bit ld, input int lv,
                               input bit en, input bit d,
                               inout int cnt, output bit ov, output bit un);
    ov = 1'b0;
    un = 1'b0;
    if (rst || clr)      cnt = rv;
    else if (ld)         cnt = (lv > maxv) ? maxv : lv;
    else if (en && d) begin
      ov  = (cnt == maxv);
      cnt = (ov && sat) ? cnt : (cnt + 1) % (maxv + 1);
    end else if (en) begin
      un  = (cnt == 0);
      cnt = (un && sat) ? cnt : (cnt + maxv) % (maxv + 1);
    end
  endfunction

  always @(posedge clk) begin
    step(9,   1'b0, 0, reset, clear, load, int'(load_value), enable, dir, ma_cnt, ma_ov, ma_un);
    step(255, 1'b1, 3, reset, clear, load, int'(load_value), enable, dir, mb_cnt, mb_ov, mb_un);
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a.out",       int'(ia.out),       ma_cnt);
      chk("a.overflow",  int'(ia.overflow),  int'(ma_ov));
      chk("a.underflow", int'(ia.underflow), int'(ma_un));
      chk("a.at_max",    int'(ia.at_max),    int'(ma_cnt == 9));
      chk("a.at_zero",   int'(ia.at_zero),   int'(ma_cnt == 0));
      chk("a.pulse_excl", int'(ia.overflow & ia.underflow), 0);
      chk("b.out",       int'(ib.out),       mb_cnt);
      chk("b.overflow",  int'(ib.overflow),  int'(mb_ov));
      chk("b.underflow", int'(ib.underflow), int'(mb_un));
      chk("b.at_max",    int'(ib.at_max),    int'(mb_cnt == 255));
      chk("b.at_zero",   int'(ib.at_zero),   int'(mb_cnt == 0));
      chk("b.pulse_excl", int'(ib.overflow & ib.underflow), 0);
    end
  end

  task automatic drive(input bit r, input bit c, input bit l, input int lv,
                       input bit e, input bit d);
    reset = r; clear = c; load = l; load_value = 8'(lv); enable = e; dir = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0; dir = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit.reset_a", ma_cnt, 0);
    chk("lit.reset_b", mb_cnt, 3);
    chk("lit.reset_a_atzero", int'(ia.at_zero), 1);

    // Count up through the wrap
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 1, 1);
      chk("lit.up_a", ma_cnt, (i + 1) % 10);
      chk("lit.up_a_ov", int'(ma_ov), int'(i == 9));
    end

    // Wrap down
    drive(0, 0, 1, 0, 0, 0);
    chk("lit.load0_a", ma_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      chk("lit.down_a", ma_cnt, 9 - i);
      chk("lit.down_a_un", int'(ma_un), int'(i == 0));
    end

    // Saturate at the top of the 8-bit range
    drive(0, 0, 1, 253, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 1);
      chk("lit.sat_b", mb_cnt, (i < 2) ? 254 + i : 255);
      chk("lit.sat_b_ov", int'(mb_ov), int'(i >= 2));
    end
    drive(0, 0, 0, 0, 1, 0);
    chk("lit.sat_b_back", mb_cnt, 254);
    chk("lit.sat_b_back_ov", int'(mb_ov), 0);

    // Priority and clamping
    drive(0, 0, 1, 200, 1, 1);
    chk("lit.clamp_a", ma_cnt, 9);
    chk("lit.clamp_a_ov", int'(ma_ov), 0);
    drive(0, 1, 1, 5, 1, 1);
    chk("lit.clear_a", ma_cnt, 0);
    chk("lit.clear_b", mb_cnt, 3);
    drive(1, 0, 1, 7, 1, 1);
    chk("lit.rst_over_load_b", mb_cnt, 3);

    // Reset mid-count
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 1);
    chk("lit.mid_a", ma_cnt, 5);
    drive(1, 0, 0, 0, 1, 1);
    chk("lit.mid_rst_a", ma_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 1);
      chk("lit.resume_a", ma_cnt, i + 1);
      chk("lit.resume_a_ov", int'(ma_ov), 0);
    end

    // Direction toggling at the boundary
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, (i % 2) == 1);
      chk("lit.toggle_a", ma_cnt, (i % 2 == 0) ? 9 : 0);
      chk("lit.toggle_a_un", int'(ma_un), int'(i % 2 == 0));
      chk("lit.toggle_a_ov", int'(ma_ov), int'(i % 2 == 1));
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(15) == 0,
            ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255)),
            $urandom_range(3) != 0, $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the 8-bit up counter. It counts up or down with a programmable modulus, selectable wrap or saturate behaviour, synchronous clear and parallel load. Registered overflow/underflow pulses and combinational boundary flags let it drive timers, address generators and event counters wherever the fixed-function up counter is too limited.

## Interface

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MAX_VALUE, 2**WIDTH-1, terminal count; legal range 1 .. 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.
- RESET_VALUE, 0, value loaded by reset and clear; must be ≤ MAX_VALUE.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous return to RESET_VALUE.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value taken on load.
- enable  in  1  count enable, one step per cycle.
- dir  in  1  1 = count up, 0 = count down.
- out  out  WIDTH  registered count.
- overflow  out  1  registered one-cycle pulse: up-step attempted at MAX_VALUE.
- underflow  out  1  registered one-cycle pulse: down-step attempted at 0.
- at_max  out  1  combinational, out == MAX_VALUE.
- at_zero  out  1  combinational, out == 0.

## Operation

- Priority per cycle: reset > clear > load > enable > hold.
- reset or clear: out <= RESET_VALUE; overflow <= 0; underflow <= 0.
- load: out <= min(load_value, MAX_VALUE). Out-of-range values are clamped, never wrapped. overflow and underflow are 0 that cycle. enable and dir are ignored.
- enable, dir=1:
  - out < MAX_VALUE: out <= out+1.
  - out == MAX_VALUE: out <= 0 (SATURATE=0) or out holds (SATURATE=1). overflow <= 1 in both modes.
- enable, dir=0:
  - out > 0: out <= out-1.
  - out == 0: out <= MAX_VALUE (SATURATE=0) or out holds (SATURATE=1). underflow <= 1 in both modes.
- No enable (and no reset, clear or load): out holds; overflow and underflow <= 0.
- Arithmetic is WIDTH bits, unsigned. The modulus is MAX_VALUE+1, so wrap never passes through values above MAX_VALUE.
- overflow and underflow are mutually exclusive and never high together.
- dir may change every cycle. No state depends on the previous direction.

## Timing

- After reset is deasserted: out = RESET_VALUE, overflow = underflow = 0, and at_max/at_zero reflect RESET_VALUE.
- Reset applied mid-count takes effect at the next edge regardless of clear, load or enable. There is no partial update.
- Latency: the effect of an input sampled at edge N is visible on out, overflow and underflow after edge N.
- overflow/underflow assert in the same cycle that out shows the wrapped (or held) value, and last exactly one cycle per boundary event.
- Saturate mode with enable held at the boundary: a pulse every cycle. These are back-to-back high cycles, not one long event; a bench counts cycles.
- at_max and at_zero have no register delay; they follow out combinationally.

## Test plan

- Reset/count up: WIDTH=8, MAX_VALUE=9, SATURATE=0; reset, then enable=1 dir=1 for 12 cycles -> out 1..9, 0, 1, 2; overflow high only in the cycle out=0; at_max high while out=9.
- Wrap down: same config, load 0 then enable dir=0 for 3 cycles -> out 9, 8, 7; underflow high only with out=9; at_zero high during the load-result cycle.
- Saturate: SATURATE=1, MAX_VALUE=255; load 253, enable up 5 cycles -> out 254, 255, 255, 255, 255; overflow high for the last 3 cycles. Then dir=0 -> out 254, overflow low.
- Priority and clamping: MAX_VALUE=9; assert load=1 (load_value=200), enable=1 together -> out=9 with no overflow. Next cycle clear=1 with load=1 -> out=RESET_VALUE. Then reset=1 with clear=0, load=1 -> out=RESET_VALUE, pulses 0.
- Reset mid-operation: count to 5, assert reset for 1 cycle while enable=1 -> out=0 after that edge and counting resumes 1, 2, … with no spurious pulse.
- Direction toggling: MAX_VALUE=9, out=0, dir alternates 0/1 with enable=1 -> out 9, 0, 9, 0; underflow and overflow alternate, never both high.
